// File: rtl/pixel_uart_pkg.sv
// pixel_uart_pkg: header constants, default sizes and FSM state types for the pixel UART bridge
package pixel_uart_pkg;
  localparam logic [15:0] HDR_SYNC = 16'hFFFF;
  localparam logic [15:0] HDR_MARK = 16'hAAAA;
  localparam int PICK_COUNT_DEF  = 5;
  localparam int FIFO_ADDR_W_DEF = 4;
  localparam int DATA_W_DEF      = 16;
  localparam int OVS_LOG2_DEF    = 4;
  localparam int UART_BITS_DEF   = 8;
  typedef enum logic [1:0] {PK_IDLE, PK_HDR1, PK_HDR2, PK_CAP} pick_state_t;
  typedef enum logic [1:0] {SR_IDLE, SR_LOAD, SR_START, SR_WAIT} ser_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/px_fifo_async.sv
// px_fifo_async: first-word-fall-through async FIFO with Gray pointers and 2-FF synchronizers
module px_fifo_async
  import pixel_uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              addi_clk,
  input  logic              uart_clk,
  input  logic              nRST,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty
);
  logic [DATA_W-1:0] r_mem [1 << ADDR_W];
  logic [ADDR_W:0]   r_wbin, r_wgray, r_rbin, r_rgray;
  logic [ADDR_W:0]   r_rg_s1, r_rg_s2, r_wg_s1, r_wg_s2;
  logic [ADDR_W:0]   w_wbin_nx, w_wgray_nx, w_rbin_nx, w_rgray_nx;
  logic              r_full, r_empty;
  assign w_wbin_nx  = r_wbin + {{ADDR_W{1'b0}}, i_wr & ~r_full};
  assign w_wgray_nx = w_wbin_nx ^ (w_wbin_nx >> 1);
  assign w_rbin_nx  = r_rbin + {{ADDR_W{1'b0}}, i_rd & ~r_empty};
  assign w_rgray_nx = w_rbin_nx ^ (w_rbin_nx >> 1);
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_rdata    = r_mem[r_rbin[ADDR_W-1:0]];
  always_ff @(posedge addi_clk)
    if (i_wr && !r_full) r_mem[r_wbin[ADDR_W-1:0]] <= i_wdata;
  // full compares against the read pointer as seen two addi_clk edges late
  always_ff @(posedge addi_clk or negedge nRST)
    if (!nRST) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_rg_s1 <= '0;
      r_rg_s2 <= '0;
      r_full  <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nx;
      r_wgray <= w_wgray_nx;
      r_rg_s1 <= r_rgray;
      r_rg_s2 <= r_rg_s1;
      r_full  <= w_wgray_nx == {~r_rg_s2[ADDR_W:ADDR_W-1], r_rg_s2[ADDR_W-2:0]};
    end
  always_ff @(posedge uart_clk or negedge nRST)
    if (!nRST) begin
      r_rbin  <= '0;
      r_rgray <= '0;
      r_wg_s1 <= '0;
      r_wg_s2 <= '0;
      r_empty <= 1'b1;
    end else begin
      r_rbin  <= w_rbin_nx;
      r_rgray <= w_rgray_nx;
      r_wg_s1 <= r_wgray;
      r_wg_s2 <= r_wg_s1;
      r_empty <= w_rgray_nx == r_wg_s2;
    end
endmodule

// File: rtl/px_pick.sv
// px_pick: detects FFFF,FFFF..,AAAA in the word stream and captures the next PICK_COUNT words
module px_pick
  import pixel_uart_pkg::*;
#(
  parameter int PICK_COUNT = PICK_COUNT_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              addi_clk,
  input  logic              nRST,
  input  logic              i_go,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_push,
  output logic [DATA_W-1:0] o_data
);
  localparam int CW = $clog2(PICK_COUNT + 1);
  pick_state_t       r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_push;
  logic [DATA_W-1:0] r_data;
  logic              w_sync, w_mark;
  assign w_sync = i_din == HDR_SYNC;
  assign w_mark = i_din == HDR_MARK;
  assign o_push = r_push;
  assign o_data = r_data;
  always_ff @(posedge addi_clk or negedge nRST)
    if (!nRST) begin
      r_state <= PK_IDLE;
      r_cnt   <= '0;
      r_push  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_push <= 1'b0;
      if (!i_go) r_state <= PK_IDLE;
      else case (r_state)
        PK_IDLE: if (w_sync) r_state <= PK_HDR1;
        PK_HDR1: r_state <= w_sync ? PK_HDR2 : PK_IDLE;
        PK_HDR2: begin
          r_state <= w_mark ? PK_CAP : w_sync ? PK_HDR2 : PK_IDLE;
          r_cnt   <= '0;
        end
        PK_CAP: begin
          r_push <= 1'b1;
          r_data <= i_din;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(PICK_COUNT - 1)) r_state <= PK_IDLE;
        end
      endcase
    end
endmodule

// File: rtl/px_uart_tx.sv
// px_uart_tx: 8N1 transmitter, 2^OVS_LOG2 clocks per bit, one-cycle done pulse after the stop bit
module px_uart_tx
  import pixel_uart_pkg::*;
#(
  parameter int OVS_LOG2  = OVS_LOG2_DEF,
  parameter int UART_BITS = UART_BITS_DEF
) (
  input  logic                 uart_clk,
  input  logic                 nRST,
  input  logic                 i_load,
  input  logic                 i_start,
  input  logic [UART_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_done
);
  localparam int BW = $clog2(UART_BITS);
  tx_state_t            r_state;
  logic [OVS_LOG2-1:0]  r_ovs;
  logic [BW-1:0]        r_bit;
  logic [UART_BITS-1:0] r_sh;
  logic                 r_tx, r_done, w_tick;
  assign w_tick = &r_ovs;
  assign o_tx   = r_tx;
  assign o_done = r_done;
  always_ff @(posedge uart_clk or negedge nRST)
    if (!nRST) begin
      r_state <= TX_IDLE;
      r_ovs   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovs  <= r_ovs + 1'b1;
      if (i_load) r_sh <= i_data;
      case (r_state)
        TX_IDLE: if (i_start) begin
          r_state <= TX_START;
          r_tx    <= 1'b0;
          r_ovs   <= '0;
        end
        TX_START: if (w_tick) begin
          r_state <= TX_DATA;
          r_tx    <= r_sh[0];
          r_sh    <= r_sh >> 1;
          r_bit   <= '0;
        end
        TX_DATA: if (w_tick) begin
          if (r_bit == BW'(UART_BITS - 1)) begin
            r_state <= TX_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tx  <= r_sh[0];
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + 1'b1;
          end
        end
        TX_STOP: if (w_tick) begin
          r_state <= TX_IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
endmodule

// File: rtl/pixel_uart_bridge.sv
// pixel_uart_bridge: captures header-framed pixel bursts and streams them MSB byte first over UART
module pixel_uart_bridge
  import pixel_uart_pkg::*;
#(
  parameter int PICK_COUNT  = PICK_COUNT_DEF,
  parameter int FIFO_ADDR_W = FIFO_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OVS_LOG2    = OVS_LOG2_DEF,
  parameter int UART_BITS   = UART_BITS_DEF
) (
  input  logic              addi_clk,
  input  logic              nRST,
  input  logic              uart_clk,
  input  logic              GO,
  input  logic [DATA_W-1:0] DIN,
  output logic              PUSH,
  output logic [DATA_W-1:0] PIXEL_DATA,
  output logic              full,
  output logic              empty,
  output logic              serialOut
);
  logic [DATA_W-1:0]    w_head;
  logic                 w_done;
  ser_state_t           r_state;
  logic                 r_lsb, r_load, r_start, r_rd;
  logic [UART_BITS-1:0] r_byte;
  px_pick #(.PICK_COUNT(PICK_COUNT), .DATA_W(DATA_W)) u_pick (
    .addi_clk(addi_clk), .nRST(nRST), .i_go(GO), .i_din(DIN),
    .o_push(PUSH), .o_data(PIXEL_DATA)
  );
  px_fifo_async #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_fifo (
    .addi_clk(addi_clk), .uart_clk(uart_clk), .nRST(nRST),
    .i_wr(PUSH), .i_wdata(PIXEL_DATA), .o_full(full),
    .i_rd(r_rd), .o_rdata(w_head), .o_empty(empty)
  );
  px_uart_tx #(.OVS_LOG2(OVS_LOG2), .UART_BITS(UART_BITS)) u_tx (
    .uart_clk(uart_clk), .nRST(nRST), .i_load(r_load), .i_start(r_start),
    .i_data(r_byte), .o_tx(serialOut), .o_done(w_done)
  );
  // the pop cycle is excluded in IDLE because empty only reflects it one edge later
  always_ff @(posedge uart_clk or negedge nRST)
    if (!nRST) begin
      r_state <= SR_IDLE;
      r_lsb   <= 1'b0;
      r_load  <= 1'b0;
      r_start <= 1'b0;
      r_rd    <= 1'b0;
      r_byte  <= '0;
    end else begin
      r_load  <= 1'b0;
      r_start <= 1'b0;
      r_rd    <= 1'b0;
      case (r_state)
        SR_IDLE: if (!empty && !r_rd) begin
          r_byte  <= w_head[DATA_W-1 -: UART_BITS];
          r_lsb   <= 1'b0;
          r_state <= SR_LOAD;
        end
        SR_LOAD: begin
          r_load  <= 1'b1;
          r_state <= SR_START;
        end
        SR_START: begin
          r_start <= 1'b1;
          r_state <= SR_WAIT;
        end
        SR_WAIT: if (w_done) begin
          if (r_lsb) begin
            r_rd    <= 1'b1;
            r_state <= SR_IDLE;
          end else begin
            r_byte  <= w_head[UART_BITS-1:0];
            r_lsb   <= 1'b1;
            r_state <= SR_LOAD;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_pixel_uart_bridge.sv
// tb_pixel_uart_bridge: directed bench for header capture, async FIFO, UART framing and reset
module tb_pixel_uart_bridge;
  logic        addi_clk = 1'b0;
  logic        uart_clk = 1'b0;
  logic        u_en     = 1'b1;
  logic        nRST     = 1'b0;
  logic        GO       = 1'b0;
  logic [15:0] DIN      = 16'h0000;
  logic        PUSH, full, empty, serialOut;
  logic [15:0] PIXEL_DATA;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] pq[$];
  logic [8:0]  rx_q[$];
  logic [7:0]  rx_b;
  logic        rx_ok;

  pixel_uart_bridge dut (
    .addi_clk(addi_clk), .nRST(nRST), .uart_clk(uart_clk), .GO(GO), .DIN(DIN),
    .PUSH(PUSH), .PIXEL_DATA(PIXEL_DATA), .full(full), .empty(empty), .serialOut(serialOut)
  );

  always #10 addi_clk = ~addi_clk;
  always #1 if (u_en) uart_clk = ~uart_clk;

  always @(negedge addi_clk) if (nRST && PUSH === 1'b1) pq.push_back(PIXEL_DATA);

  // UART receiver: samples each bit near its middle, records {framing_ok, byte}
  initial forever begin
    @(negedge uart_clk);
    if (nRST && serialOut === 1'b0) begin
      rx_ok = 1'b1;
      repeat (7) @(negedge uart_clk);
      rx_ok &= (serialOut === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge uart_clk);
        rx_b[i] = serialOut;
      end
      repeat (16) @(negedge uart_clk);
      rx_ok &= (serialOut === 1'b1);
      rx_q.push_back({rx_ok, rx_b});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] w);
    @(negedge addi_clk);
    DIN = w;
  endtask

  task automatic step(input logic [15:0] w, input logic ep, input logic [15:0] ed);
    @(negedge addi_clk);
    check("push", 32'(PUSH), 32'(ep));
    if (ep) check("pixel", 32'(PIXEL_DATA), 32'(ed));
    DIN = w;
  endtask

  task automatic burst(input logic [15:0] base);
    put(16'hFFFF);
    put(16'hFFFF);
    put(16'hAAAA);
    for (int i = 0; i < 5; i++) put(base + 16'(i));
    put(16'h0000);
    repeat (3) @(negedge addi_clk);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int k = 0; k < budget && rx_q.size() < n; k++) @(negedge addi_clk);
    repeat (40) @(negedge addi_clk);
    check("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_pix(input logic [15:0] base, input int n);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = base + 16'(i);
      check("rx_msb", 32'(rx_q[2*i]), {23'd0, 1'b1, p[15:8]});
      check("rx_lsb", 32'(rx_q[2*i+1]), {23'd0, 1'b1, p[7:0]});
    end
  endtask

  initial begin
    repeat (3) @(negedge addi_clk);
    check("rst_push", 32'(PUSH), 0);
    check("rst_pixel", 32'(PIXEL_DATA), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_serial", 32'(serialOut), 1);
    nRST = 1'b1;
    GO = 1'b1;
    // basic capture: pushes follow words AAAB..AAAF one cycle late
    for (int i = 0; i <= 20; i++)
      step((i == 0) ? 16'h0000 : (i < 3) ? 16'hFFFF : (i == 3) ? 16'hAAAA : 16'(32'hAAAB + i - 4),
           i >= 5 && i <= 9, 16'(32'hAAAB + i - 5));
    repeat (3) @(negedge addi_clk);
    check("t1_npush", 32'(pq.size()), 5);
    wait_bytes(10, 400);
    check_pix(16'hAAAB, 5);
    check("t1_empty", 32'(empty), 1);
    check("t1_idle", 32'(serialOut), 1);
    // broken header then a header with a repeated sync word
    pq.delete();
    rx_q.delete();
    put(16'hFFFF);
    put(16'hFFFF);
    put(16'h1234);
    put(16'hAAAA);
    for (int i = 1; i <= 5; i++) put(16'(i));
    repeat (3) @(negedge addi_clk);
    check("t3_nopush", 32'(pq.size()), 0);
    put(16'hFFFF);
    burst(16'hB001);
    check("t3_npush", 32'(pq.size()), 5);
    check("t3_first", 32'(pq[0]), 32'h0000B001);
    check("t3_last", 32'(pq[4]), 32'h0000B005);
    wait_bytes(10, 400);
    check_pix(16'hB001, 5);
    // GO dropped after two captured words
    pq.delete();
    rx_q.delete();
    put(16'hFFFF);
    put(16'hFFFF);
    put(16'hAAAA);
    put(16'hC001);
    put(16'hC002);
    @(negedge addi_clk);
    GO = 1'b0;
    DIN = 16'hC003;
    repeat (3) put(16'hC004);
    GO = 1'b1;
    for (int i = 1; i <= 5; i++) put(16'hD000 + 16'(i));
    repeat (3) @(negedge addi_clk);
    check("t4_npush", 32'(pq.size()), 2);
    check("t4_w0", 32'(pq[0]), 32'h0000C001);
    check("t4_w1", 32'(pq[1]), 32'h0000C002);
    wait_bytes(4, 300);
    check_pix(16'hC001, 2);
    // FIFO fill with the UART clock stopped
    pq.delete();
    rx_q.delete();
    u_en = 1'b0;
    for (int b = 0; b < 3; b++) burst(16'hE000 + 16'(5 * b));
    check("t5_not_full", 32'(full), 0);
    burst(16'hE00F);
    check("t5_full", 32'(full), 1);
    check("t5_npush", 32'(pq.size()), 20);
    check("t5_last_push", 32'(pq[19]), 32'h0000E013);
    u_en = 1'b1;
    wait_bytes(32, 1000);
    check_pix(16'hE000, 16);
    check("t5_empty", 32'(empty), 1);
    check("t5_full_clr", 32'(full), 0);
    // reset in the middle of a frame
    pq.delete();
    rx_q.delete();
    burst(16'hF001);
    for (int k = 0; k < 4000 && serialOut !== 1'b0; k++) @(negedge uart_clk);
    check("t6_frame", 32'(serialOut), 0);
    repeat (40) @(negedge uart_clk);
    nRST = 1'b0;
    #1;
    check("t6_serial", 32'(serialOut), 1);
    check("t6_empty", 32'(empty), 1);
    check("t6_push", 32'(PUSH), 0);
    repeat (3) @(negedge addi_clk);
    nRST = 1'b1;
    repeat (25) @(negedge addi_clk);
    rx_q.delete();
    check("t6_empty_after", 32'(empty), 1);
    check("t6_idle_after", 32'(serialOut), 1);
    burst(16'h1201);
    wait_bytes(10, 400);
    check_pix(16'h1201, 5);
    check("t6_empty_end", 32'(empty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pixel_uart_bridge.md
Name: pixel_uart_bridge

Overview:
- Captures a fixed-length burst of 16-bit pixels that follows a header in a word stream clocked by addi_clk.
- Passes the captured pixels through an asynchronous FIFO into the uart_clk domain.
- Sends each pixel as two UART bytes, MSB byte first, on serialOut.
- Sits between the pixel source (ADDI front end) and the host serial link.

Parameters:
- PICK_COUNT, 5: pixels captured per detected header.
- FIFO_ADDR_W, 4: FIFO address width; depth is 2^FIFO_ADDR_W = 16 words.
- DATA_W, 16: pixel and FIFO word width.
- OVS_LOG2, 4: log2 of uart_clk cycles per UART bit (16 clocks per bit).
- UART_BITS, 8: UART data bits per frame.

Ports:
- addi_clk, input, 1: pixel-domain clock.
- nRST, input, 1: asynchronous active-low reset for both domains.
- uart_clk, input, 1: UART-domain clock, asynchronous to addi_clk.
- GO, input, 1: capture enable, level-sensitive.
- DIN, input, 16: pixel/header word, sampled on posedge addi_clk.
- PUSH, output, 1: FIFO write strobe (addi_clk domain).
- PIXEL_DATA, output, 16: word being written to the FIFO.
- full, output, 1: FIFO full (addi_clk domain).
- empty, output, 1: FIFO empty (uart_clk domain).
- serialOut, output, 1: UART TX line, idle high.

Behaviour:
- Reset: nRST is asynchronous and active-low; the clock is addi_clk (plus uart_clk for the read side). Reset values: PUSH=0, PIXEL_DATA=0, full=0, empty=1, serialOut=1. Both FIFO pointers clear, and all FSMs return to their idle states.
- Capture FSM (addi_clk), states IDLE, HDR1, HDR2, CAP:
  - GO=0 in any state forces IDLE next cycle.
  - IDLE: DIN==16'hFFFF moves to HDR1.
  - HDR1: DIN==FFFF moves to HDR2; any other value returns to IDLE.
  - HDR2: DIN==16'hAAAA moves to CAP with the counter cleared; DIN==FFFF stays in HDR2; any other value returns to IDLE.
  - CAP: each cycle registers PIXEL_DATA<=DIN and PUSH<=1. After PICK_COUNT words it returns to IDLE.
  - PUSH is therefore a registered strobe, one cycle after the DIN sample, for exactly PICK_COUNT consecutive cycles.
- FIFO: asynchronous, first-word-fall-through (the head word is valid on the read side whenever empty=0).
  - Binary and Gray pointers with FIFO_ADDR_W+1 bits; 2-FF synchronizers in each direction.
  - full and empty are registered and conservative: they deassert a few destination-clock cycles late.
  - A write while full is dropped. A read while empty is ignored.
- Byte serializer FSM (uart_clk), states IDLE, LOAD, START, WAIT:
  - IDLE: when empty=0, latch the MSB byte ([15:8]) and go to LOAD.
  - LOAD, START: pulse the transmitter load and start strobes.
  - WAIT: wait for txDone. After the MSB byte, latch the LSB byte ([7:0]) and go to LOAD. After the LSB byte, pop the FIFO (1-cycle rd) and go to IDLE.
- UART transmitter: 10-bit frame of start 0, UART_BITS data bits LSB first, stop 1.
  - Each bit lasts 2^OVS_LOG2 uart_clk cycles, so a frame is 160 cycles.
  - txDone pulses for one cycle at the end of the stop bit.
  - The line stays high between frames.
- Mid-operation reset: an in-flight frame aborts, serialOut goes high immediately, and FIFO contents are discarded.

Decomposition:
- Package pixel_uart_pkg holds:
  - the header constants HDR_SYNC=16'hFFFF and HDR_MARK=16'hAAAA;
  - the enums for the capture, serializer and transmitter FSM states;
  - the default parameter values.
- Sub-modules: px_pick (capture FSM), px_fifo_async (FIFO plus synchronizers), px_uart_tx (transmitter). The serializer FSM lives in the top.

Test Plan:
- GO=1; DIN sequence 0000, FFFF, FFFF, AAAA, AAAB…AABA, one word per cycle → PUSH high for 5 cycles; PIXEL_DATA = AAAB, AAAC, AAAD, AAAE, AAAF; no further pushes.
- After the capture above, with uart_clk at 10x addi_clk → serialOut carries 10 bytes in order AA, AB, AA, AC … AA, AF. Each frame is 160 uart_clk cycles: 0, data LSB first, 1. empty=1 at the end.
- Broken header FFFF, FFFF, 1234, AAAA, then 5 words → no PUSH. Header FFFF, FFFF, FFFF, AAAA → capture starts.
- GO dropped during CAP after 2 words → exactly 2 pushes, FSM returns to IDLE.
- Hold the UART idle (no drain) and deliver 4 headers (20 pushes) → full asserts at 16 stored words; 4 words dropped; the first 16 pixels later transmit intact.
- Assert nRST mid-frame → serialOut=1 and empty=1 within a cycle of reset assertion; after release the next header transmits normally.
